// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and width limits.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned WIDTH_MAX     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used by the serial datapath.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_nxt;

    full_adder u_fa (
        .x (r_a[0]),
        .y (r_b[0]),
        .z (r_carry),
        .s (w_s),
        .c (w_c)
    );

    // New sum bit enters from the MSB side so bit 0 ends up in position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_s;
        end else begin : g_res_wn
            assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, carry, counter, and the result register published only on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            if (w_load) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub | cin;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_c;
                r_res   <= w_res_nxt;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    sum  <= w_res_nxt;
                    cout <= w_c;
                    ovf  <= r_carry ^ w_c;
                end
            end
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits, legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-010 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-011 SHALL have port sum  output  WIDTH  result; held stable from done until next accepted start.
REQ-012 SHALL have port cout  output  1  carry out of MSB; held with sum.
REQ-013 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB); held with sum.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: on start=1 SHALL load A into shift register, load B (sub=0) or ~B (sub=1), load carry register with cin (sub=0) or 1 (sub=1), clear bit counter, and go to RUN.
REQ-016 RUN: each cycle SHALL add one bit pair, LSB first, via the full-adder sub-module, shift the sum bit into the result register from the MSB side, update the carry register, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge storing bit WIDTH-1 it SHALL capture cout, ovf, and go to DONE.
REQ-018 Latency: done SHALL be high exactly WIDTH edges after the edge that sampled start, for one cycle; the next edge returns to IDLE.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing.
REQ-020 start asserted in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput of one operation per WIDTH+2 cycles).
REQ-021 Result SHALL equal (a + b + cin) mod 2^WIDTH for add and (a - b) mod 2^WIDTH for subtract; cout=1 on subtract means no borrow.
REQ-022 For WIDTH=1, ovf SHALL equal cin_msb XOR cout, with cin_msb being the initial carry.
REQ-023 sum, cout, ovf SHALL NOT change during RUN until DONE is entered (internal shift register separate from the output register).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (2-bit, IDLE=0, RUN=1, DONE=2) and the WIDTH default/max constants.
REQ-027 The one-bit adder SHALL be a separate combinational sub-module full_adder (x, y, z -> s, c), instantiated once; no other sub-modules.
REQ-028 Counter width SHALL be clog2(WIDTH+1) bits.

Verification (WIDTH=8 unless stated)
REQ-029 add a=0x0F, b=0x01, cin=0 -> done after 8 edges, sum=0x10, cout=0, ovf=0; add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
REQ-030 sub a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
REQ-031 start pulsed again at RUN cycle 3 with different operands -> ignored, result reflects first operands only, exactly one done pulse.
REQ-032 rst_n low at RUN cycle 4 -> busy=0, sum=0 immediately, no done; fresh 0x12+0x34 afterward -> sum=0x46.
REQ-033 WIDTH=1, all 8 combinations of a, b, cin -> {cout,sum} matches full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1); done 1 edge after start.
REQ-034 Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles, sum stable between done pulses.
